// File: rtl/rsu_sequencer.sv
// Command sequencer for the remote-system-update IP: strobe handshakes,
// read-all and boot sequences, plus a periodic watchdog kick.
module rsu_sequencer #(
   parameter int CDataW     = 32,
   parameter int CParamLast = 5,
   parameter int CAckGuard  = 4,
   parameter int CTimeout   = 1024,
   parameter int CWdPeriod  = 200
) (
   input  logic              AClkH,
   input  logic              AResetH,
   input  logic              AClkHEn,
   input  logic              ACmdStart,
   input  logic [1:0]        ACmdOp,
   input  logic [2:0]        ACmdParam,
   input  logic [1:0]        ACmdSrc,
   input  logic [CDataW-1:0] ACmdData,
   output logic              ACmdBusy,
   output logic              ACmdDone,
   output logic              ACmdErr,
   output logic [CDataW-1:0] ARdData,
   output logic [2:0]        ARdIdx,
   output logic              ARdValid,
   input  logic              AWdEn,
   output logic [2:0]        ARsuParam,
   output logic [1:0]        ARsuReadSource,
   output logic [CDataW-1:0] ARsuDataIn,
   output logic              ARsuWrite,
   output logic              ARsuRead,
   output logic              ARsuReconfig,
   output logic              ARsuResetTimer,
   input  logic              ARsuBusy,
   input  logic [CDataW-1:0] ARsuDataOut
);

   localparam int TW = $clog2(CTimeout + CAckGuard + 1);
   localparam int WW = $clog2(CWdPeriod);
   localparam logic [TW-1:0] TGUARD = TW'(CAckGuard);
   localparam logic [TW-1:0] TLAST = TW'(CTimeout - 1);
   localparam logic [WW-1:0] WLAST = WW'(CWdPeriod - 1);
   localparam logic [2:0] PLAST = 3'(CParamLast);

   typedef enum logic [2:0] {
      IDLE, ISSUE, WAIT_ACK, WAIT_DONE, NEXT, RECONF, DONE
   } state_t;

   state_t state;
   logic [1:0] op;
   logic [1:0] src;
   logic [2:0] idx;
   logic [2:0] start_idx;
   logic [TW-1:0] tmr;
   logic [WW-1:0] wd;

   assign start_idx = (ACmdOp == 2'd3) ? 3'd0 :
                      (ACmdOp == 2'd2) ? 3'd4 : ACmdParam;

   always_ff @(posedge AClkH) begin
      if (AResetH) begin
         state          <= IDLE;
         op             <= '0;
         src            <= '0;
         idx            <= '0;
         tmr            <= '0;
         wd             <= '0;
         ACmdBusy       <= 1'b0;
         ACmdDone       <= 1'b0;
         ACmdErr        <= 1'b0;
         ARdData        <= '0;
         ARdIdx         <= '0;
         ARdValid       <= 1'b0;
         ARsuParam      <= '0;
         ARsuReadSource <= '0;
         ARsuDataIn     <= '0;
         ARsuWrite      <= 1'b0;
         ARsuRead       <= 1'b0;
         ARsuReconfig   <= 1'b0;
         ARsuResetTimer <= 1'b0;
      end else if (AClkHEn) begin
         ARsuWrite <= 1'b0;
         ARsuRead  <= 1'b0;
         ARdValid  <= 1'b0;
         ACmdDone  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (ACmdStart) begin
                  op             <= ACmdOp;
                  src            <= ACmdSrc;
                  idx            <= start_idx;
                  tmr            <= '0;
                  ACmdErr        <= 1'b0;
                  ACmdBusy       <= 1'b1;
                  ARsuDataIn     <= ACmdData;
                  ARsuParam      <= start_idx;
                  ARsuReadSource <= ACmdOp[0] ? ACmdSrc : 2'd0;
                  ARsuWrite      <= ~ACmdOp[0];
                  ARsuRead       <= ACmdOp[0];
                  state          <= ISSUE;
               end
            end
            ISSUE: begin
               tmr   <= tmr + TW'(1);
               state <= WAIT_ACK;
            end
            // busy winning over guard expiry in the same cycle is harmless
            WAIT_ACK: begin
               tmr <= tmr + TW'(1);
               if (ARsuBusy || tmr == TGUARD)
                  state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               tmr <= tmr + TW'(1);
               if (!ARsuBusy) begin
                  if (op[0]) begin
                     ARdData  <= ARsuDataOut;
                     ARdIdx   <= idx;
                     ARdValid <= 1'b1;
                  end
                  state <= NEXT;
               end else if (tmr >= TLAST) begin
                  ACmdErr  <= 1'b1;
                  ACmdDone <= 1'b1;
                  state    <= DONE;
               end
            end
            NEXT: begin
               if (op == 2'd3 && idx < PLAST) begin
                  idx       <= idx + 3'd1;
                  ARsuParam <= idx + 3'd1;
                  ARsuRead  <= 1'b1;
                  tmr       <= '0;
                  state     <= ISSUE;
               end else if (op == 2'd2) begin
                  ARsuReconfig <= 1'b1;
                  state        <= RECONF;
               end else begin
                  ACmdDone <= 1'b1;
                  state    <= DONE;
               end
            end
            // the IP reloads the device; only reset leaves this state
            RECONF: state <= RECONF;
            DONE: begin
               ACmdBusy <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (!AWdEn) begin
            wd             <= '0;
            ARsuResetTimer <= 1'b0;
         end else if (state == RECONF) begin
            ARsuResetTimer <= 1'b0;
         end else if (wd == WLAST) begin
            wd             <= '0;
            ARsuResetTimer <= 1'b1;
         end else begin
            wd             <= wd + WW'(1);
            ARsuResetTimer <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rsu_sequencer.sv
// Directed bench for rsu_sequencer with a small behavioural IP model.
module tb_rsu_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        AResetH;
   logic        AClkHEn;
   logic        ACmdStart;
   logic [1:0]  ACmdOp;
   logic [2:0]  ACmdParam;
   logic [1:0]  ACmdSrc;
   logic [31:0] ACmdData;
   logic        ACmdBusy;
   logic        ACmdDone;
   logic        ACmdErr;
   logic [31:0] ARdData;
   logic [2:0]  ARdIdx;
   logic        ARdValid;
   logic        AWdEn;
   logic [2:0]  ARsuParam;
   logic [1:0]  ARsuReadSource;
   logic [31:0] ARsuDataIn;
   logic        ARsuWrite;
   logic        ARsuRead;
   logic        ARsuReconfig;
   logic        ARsuResetTimer;
   logic        ARsuBusy;
   logic [31:0] ARsuDataOut;

   rsu_sequencer dut (
      .AClkH(clk),
      .AResetH(AResetH),
      .AClkHEn(AClkHEn),
      .ACmdStart(ACmdStart),
      .ACmdOp(ACmdOp),
      .ACmdParam(ACmdParam),
      .ACmdSrc(ACmdSrc),
      .ACmdData(ACmdData),
      .ACmdBusy(ACmdBusy),
      .ACmdDone(ACmdDone),
      .ACmdErr(ACmdErr),
      .ARdData(ARdData),
      .ARdIdx(ARdIdx),
      .ARdValid(ARdValid),
      .AWdEn(AWdEn),
      .ARsuParam(ARsuParam),
      .ARsuReadSource(ARsuReadSource),
      .ARsuDataIn(ARsuDataIn),
      .ARsuWrite(ARsuWrite),
      .ARsuRead(ARsuRead),
      .ARsuReconfig(ARsuReconfig),
      .ARsuResetTimer(ARsuResetTimer),
      .ARsuBusy(ARsuBusy),
      .ARsuDataOut(ARsuDataOut)
   );

   // IP model: busy for ip_len cycles after a strobe
   int          ip_len = 5;
   logic        ip_fixed = 1'b0;
   logic [31:0] ip_val = '0;
   logic        ip_stuck = 1'b0;
   logic        ip_silent = 1'b0;
   int          ip_cnt = 0;
   logic [31:0] ip_out = '0;

   assign ARsuBusy = ip_stuck | (ip_cnt != 0);
   assign ARsuDataOut = ip_out;

   always @(posedge clk) begin
      if (AResetH) begin
         ip_cnt <= 0;
      end else if (AClkHEn) begin
         if ((ARsuWrite || ARsuRead) && !ip_silent) begin
            ip_cnt <= ip_len;
            ip_out <= ip_fixed ? ip_val : 32'h10 + 32'(ARsuParam);
         end else if (ip_cnt != 0) begin
            ip_cnt <= ip_cnt - 1;
         end
      end
   end

   int          ncyc = 0;
   int          n_wr = 0;
   int          n_rd = 0;
   int          n_done = 0;
   int          n_rt = 0;
   int          rv_n = 0;
   int          vld_cyc = 0;
   int          done_cyc = 0;
   logic [2:0]  w_param = '0;
   logic [31:0] w_data = '0;
   logic [1:0]  w_src = '0;
   logic [2:0]  r_param = '0;
   logic [1:0]  r_src = '0;
   logic [2:0]  rv_idx [64];
   logic [31:0] rv_dat [64];

   always @(negedge clk) begin
      ncyc++;
      if (ARsuWrite) begin
         n_wr++;
         w_param = ARsuParam;
         w_data  = ARsuDataIn;
         w_src   = ARsuReadSource;
      end
      if (ARsuRead) begin
         n_rd++;
         r_param = ARsuParam;
         r_src   = ARsuReadSource;
      end
      if (ARdValid && rv_n < 64) begin
         rv_idx[rv_n] = ARdIdx;
         rv_dat[rv_n] = ARdData;
         rv_n++;
         vld_cyc = ncyc;
      end
      if (ACmdDone) begin
         n_done++;
         done_cyc = ncyc;
      end
      if (ARsuResetTimer) n_rt++;
   end

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", tag, got, exp);
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic cmd(input logic [1:0] o, input logic [2:0] p,
                      input logic [1:0] s, input logic [31:0] d);
      @(negedge clk);
      ACmdStart = 1'b1;
      ACmdOp    = o;
      ACmdParam = p;
      ACmdSrc   = s;
      ACmdData  = d;
      @(negedge clk);
      ACmdStart = 1'b0;
   endtask

   task automatic wait_done(input int max, output int lat);
      lat = 1;
      while (!ACmdDone && lat < max) begin
         @(negedge clk);
         lat++;
      end
      if (!ACmdDone) lat = -1;
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got stuck want finish");
      $fatal(1, "timeout");
   end

   int lat;
   int b_wr, b_rd, b_done, b_rt, b_rv;
   int wd_hits [$];

   initial begin
      AResetH = 1'b1;
      AClkHEn = 1'b1;
      ACmdStart = 1'b0;
      ACmdOp = '0;
      ACmdParam = '0;
      ACmdSrc = '0;
      ACmdData = '0;
      AWdEn = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_flags", {ACmdBusy, ACmdDone, ACmdErr, ARdValid, ARsuWrite,
           ARsuRead, ARsuReconfig, ARsuResetTimer}, 0);
      chk("rst_fields", {ARsuParam, ARsuReadSource, ARdIdx, ARsuDataIn,
           ARdData}, 0);
      AResetH = 1'b0;

      // watchdog: period, clock-enable hold, AWdEn restart
      @(negedge clk);
      AWdEn = 1'b1;
      for (int n = 1; n <= 1000; n++) begin
         @(negedge clk);
         if (ARsuResetTimer) wd_hits.push_back(n);
         if (n == 250) AClkHEn = 1'b0;
         if (n == 300) AClkHEn = 1'b1;
         if (n == 750) AWdEn = 1'b0;
         if (n == 760) AWdEn = 1'b1;
      end
      AWdEn = 1'b0;
      chk("wd_count", wd_hits.size(), 4);
      if (wd_hits.size() == 4) begin
         chk("wd_first", wd_hits[0], 200);
         chk("wd_hold_en", wd_hits[1], 450);
         chk("wd_period", wd_hits[2], 650);
         chk("wd_restart", wd_hits[3], 960);
      end

      // write param 3
      settle();
      ip_len = 5;
      b_wr = n_wr; b_rd = n_rd; b_done = n_done;
      cmd(2'd0, 3'd3, 2'd2, 32'h1);
      chk("wr_busy", ACmdBusy, 1);
      wait_done(50, lat);
      chk("wr_lat", lat, 9);
      chk("wr_cnt", n_wr - b_wr, 1);
      chk("wr_param", w_param, 3);
      chk("wr_data", w_data, 32'h1);
      chk("wr_src", w_src, 0);
      chk("wr_nord", n_rd - b_rd, 0);
      chk("wr_err", ACmdErr, 0);
      settle();
      chk("wr_idle", ACmdBusy, 0);
      chk("wr_done", n_done - b_done, 1);

      // read param 2, src 1
      ip_len = 3; ip_fixed = 1'b1; ip_val = 32'hA5A5;
      b_wr = n_wr; b_rd = n_rd; b_rv = rv_n;
      cmd(2'd1, 3'd2, 2'd1, 32'h0);
      wait_done(50, lat);
      chk("rd_lat_ok", lat > 0, 1);
      chk("rd_cnt", n_rd - b_rd, 1);
      chk("rd_param", r_param, 2);
      chk("rd_src", r_src, 1);
      chk("rd_nowr", n_wr - b_wr, 0);
      chk("rd_vld", rv_n - b_rv, 1);
      chk("rd_data", ARdData, 32'hA5A5);
      chk("rd_idx", ARdIdx, 2);
      chk("rd_order", done_cyc - vld_cyc, 1);

      // read all
      settle();
      ip_len = 2; ip_fixed = 1'b0;
      b_rd = n_rd; b_rv = rv_n; b_done = n_done;
      cmd(2'd3, 3'd6, 2'd2, 32'h0);
      wait_done(200, lat);
      settle();
      chk("ra_lat_ok", lat > 0, 1);
      chk("ra_vld", rv_n - b_rv, 6);
      chk("ra_reads", n_rd - b_rd, 6);
      chk("ra_src", r_src, 2);
      chk("ra_done", n_done - b_done, 1);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("ra_idx%0d", i), rv_idx[b_rv + i], i);
         chk($sformatf("ra_dat%0d", i), rv_dat[b_rv + i], 32'h10 + i);
      end

      // busy stuck high -> timeout, kicks continue
      ip_stuck = 1'b1;
      b_done = n_done; b_rt = n_rt;
      AWdEn = 1'b1;
      cmd(2'd0, 3'd0, 2'd0, 32'h9);
      wait_done(1100, lat);
      AWdEn = 1'b0;
      chk("to_lat", lat, 1025);
      chk("to_err", ACmdErr, 1);
      chk("to_done", n_done - b_done, 1);
      chk("to_kicks", n_rt - b_rt, 5);
      ip_stuck = 1'b0;

      // IP never raises busy: guard completes, error cleared
      settle();
      ip_silent = 1'b1;
      b_wr = n_wr;
      cmd(2'd0, 3'd1, 2'd0, 32'h55);
      chk("gd_errclr", ACmdErr, 0);
      wait_done(50, lat);
      chk("gd_lat", lat, 8);
      chk("gd_err", ACmdErr, 0);
      chk("gd_wr", n_wr - b_wr, 1);
      ip_silent = 1'b0;

      // start while busy is ignored
      settle();
      ip_len = 20;
      b_wr = n_wr; b_rd = n_rd; b_done = n_done;
      cmd(2'd0, 3'd1, 2'd0, 32'h7);
      repeat (4) @(negedge clk);
      ACmdStart = 1'b1; ACmdOp = 2'd1; ACmdParam = 3'd6;
      @(negedge clk);
      ACmdStart = 1'b0;
      wait_done(100, lat);
      settle();
      settle();
      chk("ig_lat_ok", lat > 0, 1);
      chk("ig_nord", n_rd - b_rd, 0);
      chk("ig_wr", n_wr - b_wr, 1);
      chk("ig_param", w_param, 1);
      chk("ig_done", n_done - b_done, 1);
      chk("ig_idle", ACmdBusy, 0);

      // reset mid-read
      ip_len = 50;
      cmd(2'd1, 3'd3, 2'd2, 32'hDEAD);
      repeat (10) @(negedge clk);
      chk("mr_busy", ACmdBusy, 1);
      AResetH = 1'b1;
      @(negedge clk);
      AResetH = 1'b0;
      chk("mr_flags", {ACmdBusy, ACmdDone, ACmdErr, ARdValid, ARsuWrite,
           ARsuRead, ARsuReconfig, ARsuResetTimer}, 0);
      chk("mr_fields", {ARsuParam, ARsuReadSource, ARdIdx, ARsuDataIn,
           ARdData}, 0);
      repeat (5) settle();
      chk("mr_idle", ACmdBusy, 0);

      // boot
      ip_len = 3;
      AWdEn = 1'b1;
      b_wr = n_wr; b_done = n_done;
      cmd(2'd2, 3'd1, 2'd3, 32'h0020_0000);
      lat = 0;
      while (!ARsuReconfig && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      chk("bt_reconf", ARsuReconfig, 1);
      chk("bt_wr", n_wr - b_wr, 1);
      chk("bt_param", w_param, 4);
      chk("bt_data", w_data, 32'h0020_0000);
      chk("bt_src", w_src, 0);
      repeat (2) settle();
      b_rt = n_rt;
      repeat (450) settle();
      chk("bt_hold", ARsuReconfig, 1);
      chk("bt_busy", ACmdBusy, 1);
      chk("bt_nodone", n_done - b_done, 0);
      chk("bt_nokick", n_rt - b_rt, 0);
      AResetH = 1'b1;
      @(negedge clk);
      AResetH = 1'b0;
      chk("bt_rst", {ARsuReconfig, ACmdBusy}, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/rsu_sequencer.md
Name: rsu_sequencer

Overview:
- Sequencer for the remote-system-update IP. It turns single CPU-side commands into correctly handshaked write_param/read_param strobes, multi-step "read all parameters" and "boot image" sequences, and a periodic watchdog kick.
- Placed between the system-update I/O register file and the update IP core; it replaces direct register-driven strobes.

Parameters:
- CDataW, 32, width of parameter data (24 for S25FL128 builds)
- CParamLast, 5, highest parameter index visited by read-all
- CAckGuard, 4, cycles allowed for IP busy to rise after a strobe
- CTimeout, 1024, max cycles busy may stay high
- CWdPeriod, 200, watchdog kick period in enabled cycles (min 2)

Ports:
- AClkH  in  1  clock
- AResetH  in  1  synchronous reset, active-high
- AClkHEn  in  1  clock enable; when 0 all state holds
- ACmdStart  in  1  command request, sampled in IDLE only
- ACmdOp  in  2  0=write param, 1=read param, 2=boot, 3=read all
- ACmdParam  in  3  parameter index (ops 0,1)
- ACmdSrc  in  2  read_source (ops 1,3)
- ACmdData  in  CDataW  write data / boot address
- ACmdBusy  out  1  sequencer not IDLE
- ACmdDone  out  1  1-cycle pulse at command completion
- ACmdErr  out  1  sticky timeout flag, cleared by next accepted start
- ARdData  out  CDataW  captured read data
- ARdIdx  out  3  parameter index of ARdData
- ARdValid  out  1  1-cycle pulse per captured read
- AWdEn  in  1  enables watchdog kicking
- ARsuParam  out  3  to IP param
- ARsuReadSource  out  2  to IP read_source
- ARsuDataIn  out  CDataW  to IP data_in
- ARsuWrite  out  1  to IP write_param
- ARsuRead  out  1  to IP read_param
- ARsuReconfig  out  1  to IP reconfig
- ARsuResetTimer  out  1  to IP reset_timer
- ARsuBusy  in  1  from IP busy
- ARsuDataOut  in  CDataW  from IP data_out

Behaviour:
- Reset: FSM=IDLE; all outputs 0; index, timers and watchdog counter 0; ACmdErr=0.
- All sequential updates occur only when AClkHEn=1, including strobe, timeout and guard counting.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, NEXT, RECONF, DONE.
- IDLE: on ACmdStart, latch op/param/src/data, clear ACmdErr and set index = (op==3 ? 0 : op==2 ? 4 : ACmdParam), then go to ISSUE. ACmdStart outside IDLE is ignored.
- ISSUE (1 cycle): drive ARsuParam=index and ARsuReadSource=src (0 for writes). ARsuDataIn holds the latched data for the whole command. Pulse ARsuWrite (ops 0,2) or ARsuRead (ops 1,3) for exactly one cycle. Next state is WAIT_ACK.
- ARsuParam and ARsuReadSource are held stable from ISSUE until the step leaves WAIT_DONE.
- WAIT_ACK: when ARsuBusy=1, go to WAIT_DONE. If busy has not risen after CAckGuard cycles, the step is treated as complete and the FSM goes to WAIT_DONE; this is not an error.
- WAIT_DONE: when ARsuBusy=0, the step ends.
  - For reads, capture ARdData=ARsuDataOut and ARdIdx=index in the same cycle busy is seen low, and pulse ARdValid on the next cycle.
  - Then go to NEXT.
  - If busy stays high CTimeout cycles, counted from ISSUE, set ACmdErr and go to DONE, abandoning the remaining steps.
- NEXT:
  - op 3: if index<CParamLast, increment index and go to ISSUE; otherwise go to DONE.
  - op 2: go to RECONF.
  - ops 0,1: go to DONE.
- RECONF: ARsuReconfig=1, held until reset; ACmdBusy stays 1; ACmdDone is never pulsed. The watchdog is suppressed.
- DONE: pulse ACmdDone for 1 cycle, then go to IDLE.
- ACmdBusy = (state != IDLE).
- Watchdog: free-running counter 0..CWdPeriod-1, counting only while AWdEn=1 and the FSM is not in RECONF.
  - At value CWdPeriod-1, ARsuResetTimer pulses 1 cycle and the counter wraps to 0.
  - AWdEn=0 clears the counter to 0.
  - The kick is independent of the command FSM; kicks continue during WAIT states.
- Simultaneous events: the guard expiry and the busy rise in the same cycle count as a busy rise. Reset mid-command returns to IDLE in one cycle with all strobes deasserted.

Test Plan:
- Write param 3, data 0x1, IP busy high for 5 cycles -> single ARsuWrite pulse with ARsuParam=3 and ARsuDataIn=1; ACmdDone about 8 cycles after start; ACmdErr=0.
- Read param 2, src 1, IP returns 0xA5A5 -> ARsuRead pulse with ARsuReadSource=1; ARdData=0xA5A5, ARdIdx=2; ARdValid then ACmdDone.
- Read-all with IP returning 0x10+idx -> six ARdValid pulses in idx order 0..5 with data 0x10..0x15, then exactly one ACmdDone.
- Boot, data 0x00200000 -> write to param 4 with that data, then ARsuReconfig=1 held indefinitely; ACmdDone never pulses; watchdog pulses stop.
- IP busy stuck high -> ACmdErr=1 at CTimeout and ACmdDone pulses. The next start clears ACmdErr. An IP that never raises busy completes via the CAckGuard path with no error.
- AWdEn=1 with CWdPeriod=200 -> ARsuResetTimer pulses every 200 cycles, holding while AClkHEn=0. Deasserting AWdEn restarts the count. ACmdStart while busy is ignored, and reset mid-read gives IDLE with all outputs 0.
